// File: rtl/mmb_router.sv
`default_nettype none
// ============================================================================
// Module   : mmb_router
// Purpose  : Routes one burst-capable master to SLAVES slaves by address,
//            holding write bursts on one slave and keeping read return in order.
// Revision : 1.0 - initial release
// ============================================================================
module mmb_router #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int BWIDTH  = 4,
    parameter int SLAVES  = 4,
    parameter int RDPENDS = 3
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic [AWIDTH-1:0]             s_addr,
    input  logic [BWIDTH-1:0]             s_bcnt,
    input  logic                          s_wreq,
    input  logic [DWIDTH-1:0]             s_wdat,
    input  logic                          s_rreq,
    output logic [DWIDTH-1:0]             s_rdat,
    output logic                          s_rval,
    output logic                          s_busy,
    output logic [SLAVES-1:0][AWIDTH-1:0] m_addr,
    output logic [SLAVES-1:0][BWIDTH-1:0] m_bcnt,
    output logic [SLAVES-1:0]             m_wreq,
    output logic [SLAVES-1:0][DWIDTH-1:0] m_wdat,
    output logic [SLAVES-1:0]             m_rreq,
    input  logic [SLAVES-1:0][DWIDTH-1:0] m_rdat,
    input  logic [SLAVES-1:0]             m_rval,
    input  logic [SLAVES-1:0]             m_busy
);
    localparam int SEL    = $clog2(SLAVES);
    localparam int LWIDTH = BWIDTH + 1;
    localparam int PWIDTH = BWIDTH + $clog2(RDPENDS) + 1;
    localparam int CWIDTH = $clog2(RDPENDS + 1);
    localparam int PTRW   = (RDPENDS > 1) ? $clog2(RDPENDS) : 1;
    localparam logic [CWIDTH-1:0] C_TFULL    = CWIDTH'(RDPENDS);
    localparam logic [PTRW-1:0]   C_PTR_LAST = PTRW'(RDPENDS - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } wstate_t;

    wstate_t           r_state;
    wstate_t           w_state_nxt;
    logic [SEL-1:0]    r_wsel;
    logic [SEL-1:0]    w_wsel_nxt;
    logic [BWIDTH-1:0] r_wrem;
    logic [BWIDTH-1:0] w_wrem_nxt;

    logic [LWIDTH-1:0] r_fifo [RDPENDS];
    logic [PTRW-1:0]   r_wptr;
    logic [PTRW-1:0]   r_rptr;
    logic [CWIDTH-1:0] r_tcnt;
    logic [PWIDTH-1:0] r_pend;
    logic [SEL-1:0]    r_rd_sel;
    logic              r_rval;
    logic [DWIDTH-1:0] r_rdat;

    logic [SEL-1:0]    w_tsel;
    logic [SEL-1:0]    w_wtgt;
    logic [LWIDTH-1:0] w_len;
    logic [PWIDTH-1:0] w_pend_add;
    logic              w_rstall;
    logic              w_wacc;
    logic              w_racc;
    logic              w_rword;
    logic              w_pop;

    assign w_tsel = s_addr[AWIDTH-1 -: SEL];
    // Burst continuation words follow the latched slave, not the live address.
    assign w_wtgt = (r_state == WBURST) ? r_wsel : w_tsel;
    assign w_len  = LWIDTH'(s_bcnt) + LWIDTH'(1);

    assign w_rstall = (r_state == WBURST)
                    | (r_tcnt == C_TFULL)
                    | ((r_pend != '0) & (r_rd_sel != w_tsel));
    assign s_busy   = m_busy[w_wtgt] | (s_rreq & w_rstall);
    assign w_wacc   = s_wreq & ~s_busy;
    assign w_racc   = s_rreq & ~s_busy;

    // Words from any slave other than rd_sel, or with nothing pending, are dropped.
    assign w_rword    = m_rval[r_rd_sel] & (r_pend != '0);
    assign w_pop      = w_rword & (r_fifo[r_rptr] == LWIDTH'(1));
    assign w_pend_add = w_racc ? PWIDTH'(w_len) : '0;

    for (genvar j = 0; j < SLAVES; j++) begin : g_slave
        assign m_addr[j] = s_addr;
        assign m_bcnt[j] = s_bcnt;
        assign m_wdat[j] = s_wdat;
        assign m_wreq[j] = ~reset & s_wreq & (w_wtgt == SEL'(j));
        assign m_rreq[j] = ~reset & s_rreq & ~w_rstall & (w_tsel == SEL'(j));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wsel_nxt  = r_wsel;
        w_wrem_nxt  = r_wrem;
        case (r_state)
            IDLE: begin
                if (w_wacc && (s_bcnt != '0)) begin
                    w_state_nxt = WBURST;
                    w_wsel_nxt  = w_tsel;
                    w_wrem_nxt  = s_bcnt;
                end
            end
            WBURST: begin
                if (w_wacc) begin
                    w_wrem_nxt = r_wrem - BWIDTH'(1);
                    if (r_wrem == BWIDTH'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wsel  <= '0;
            r_wrem  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wsel  <= w_wsel_nxt;
            r_wrem  <= w_wrem_nxt;
        end
    end

    // Each FIFO entry holds the words still owed by one outstanding read.
    // Push and head-decrement never share an entry: pushes need a non-full
    // FIFO and word returns need a non-empty one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RDPENDS; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_tcnt   <= '0;
            r_pend   <= '0;
            r_rd_sel <= '0;
            r_rval   <= 1'b0;
            r_rdat   <= '0;
        end else begin
            if (w_racc) begin
                r_fifo[r_wptr] <= w_len;
                r_wptr         <= (r_wptr == C_PTR_LAST) ? '0 : r_wptr + PTRW'(1);
                r_rd_sel       <= w_tsel;
            end
            if (w_rword) begin
                if (w_pop) begin
                    r_rptr <= (r_rptr == C_PTR_LAST) ? '0 : r_rptr + PTRW'(1);
                end else begin
                    r_fifo[r_rptr] <= r_fifo[r_rptr] - LWIDTH'(1);
                end
                r_rdat <= m_rdat[r_rd_sel];
            end
            r_tcnt <= r_tcnt + CWIDTH'(w_racc) - CWIDTH'(w_pop);
            r_pend <= r_pend + w_pend_add - PWIDTH'(w_rword);
            r_rval <= w_rword;
        end
    end

    assign s_rdat = r_rdat;
    assign s_rval = r_rval;

endmodule
`default_nettype wire

// File: tb/tb_mmb_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmb_router
// Purpose  : Scoreboard bench for mmb_router with write monitor and a
//            latency-modelled read slave per port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmb_router;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int NS = 4;
    localparam int RP = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [AW-1:0]         s_addr;
    logic [BW-1:0]         s_bcnt;
    logic                  s_wreq;
    logic [DW-1:0]         s_wdat;
    logic                  s_rreq;
    logic [DW-1:0]         s_rdat;
    logic                  s_rval;
    logic                  s_busy;
    logic [NS-1:0][AW-1:0] m_addr;
    logic [NS-1:0][BW-1:0] m_bcnt;
    logic [NS-1:0]         m_wreq;
    logic [NS-1:0][DW-1:0] m_wdat;
    logic [NS-1:0]         m_rreq;
    logic [NS-1:0][DW-1:0] m_rdat;
    logic [NS-1:0]         m_rval;
    logic [NS-1:0]         m_busy;

    logic [NS-1:0]         model_rval = '0;
    logic [NS-1:0][DW-1:0] model_rdat = '0;
    logic [NS-1:0]         spur       = '0;
    logic [NS-1:0]         busy_v     = '0;
    assign m_rval = model_rval | spur;
    assign m_rdat = model_rdat;
    assign m_busy = busy_v;

    mmb_router #(
        .AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .SLAVES(NS), .RDPENDS(RP)
    ) dut (
        .reset(reset), .clk(clk),
        .s_addr(s_addr), .s_bcnt(s_bcnt), .s_wreq(s_wreq), .s_wdat(s_wdat),
        .s_rreq(s_rreq), .s_rdat(s_rdat), .s_rval(s_rval), .s_busy(s_busy),
        .m_addr(m_addr), .m_bcnt(m_bcnt), .m_wreq(m_wreq), .m_wdat(m_wdat),
        .m_rreq(m_rreq), .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int rcount = 0;
    int lat    = 3;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rword_t;

    rword_t        sq [NS][$];
    int            last_due [NS];
    logic [5:0]    scnt [NS];
    logic [5:0]    pcnt [NS];
    logic [DW-1:0] exp_r [$];
    logic [9:0]    exp_w [$];

    logic [DW-1:0] mon_e;
    logic [9:0]    mon_w;
    int            cap_d;
    rword_t        cap_item;

    always @(posedge clk) cyc++;

    // Read slave model: accepted requests return L words in order after lat cycles.
    always @(negedge clk) begin
        for (int j = 0; j < NS; j++) begin
            if (m_rreq[j] && !m_busy[j]) begin
                cap_d = cyc + lat;
                if (cap_d <= last_due[j]) cap_d = last_due[j] + 1;
                for (int k = 0; k <= int'(m_bcnt[j]); k++) begin
                    cap_item.due  = cap_d + k;
                    cap_item.data = {2'(j), scnt[j]};
                    sq[j].push_back(cap_item);
                    scnt[j]++;
                    last_due[j] = cap_d + k;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int j = 0; j < NS; j++) begin
            if (sq[j].size() != 0 && sq[j][0].due <= cyc) begin
                model_rval[j] = 1'b1;
                model_rdat[j] = sq[j][0].data;
                void'(sq[j].pop_front());
            end else begin
                model_rval[j] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < NS; j++) begin
            if (m_wreq[j] && !m_busy[j]) begin
                n_vec++;
                if (exp_w.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: slave %0d got data %h, required no write", j, m_wdat[j]);
                end else begin
                    mon_w = exp_w.pop_front();
                    if ({2'(j), m_wdat[j]} !== mon_w) begin
                        n_err++;
                        $display("FAIL wr_route: got slave %0d data %h, required slave %0d data %h",
                                 j, m_wdat[j], mon_w[9:8], mon_w[7:0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_rval === 1'b1) begin
            rcount++;
            n_vec++;
            if (exp_r.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got s_rval=1 s_rdat=%h, required s_rval=0", s_rdat);
            end else begin
                mon_e = exp_r.pop_front();
                if (s_rdat !== mon_e) begin
                    n_err++;
                    $display("FAIL rd_data: got %h, required %h", s_rdat, mon_e);
                end
            end
        end
    end

    function automatic bit sq_pending();
        for (int j = 0; j < NS; j++) begin
            if (sq[j].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_r.size() != 0 || sq_pending()) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_r.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d read words outstanding, required 0", nm, exp_r.size());
        end
    endtask

    task automatic wr_burst(input logic [7:0] addr, input logic [3:0] bcnt, input logic [7:0] d0,
                            input logic [7:0] alt, input int nwords);
        logic [1:0] tgt;
        int n;
        tgt = addr[7:6];
        for (int k = 0; k < nwords; k++) begin
            @(posedge clk); #1;
            s_wreq = 1'b1;
            s_addr = (k == 1) ? alt : addr;
            s_bcnt = bcnt;
            s_wdat = d0 + 8'(k);
            exp_w.push_back({tgt, s_wdat});
            n = 0;
            @(negedge clk);
            while (s_busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (s_busy) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_timeout: word %0d got s_busy=1 for 100 cycles, required acceptance", k);
            end else if (k == 0) begin
                n_vec++;
                for (int j = 0; j < NS; j++) begin
                    if (m_addr[j] !== s_addr || m_bcnt[j] !== s_bcnt || m_wdat[j] !== s_wdat) begin
                        n_err++;
                        $display("FAIL bcast: slave %0d got %h/%h/%h, required %h/%h/%h",
                                 j, m_addr[j], m_bcnt[j], m_wdat[j], s_addr, s_bcnt, s_wdat);
                        break;
                    end
                end
            end
        end
        @(posedge clk); #1;
        s_wreq = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [3:0] bcnt, output int waited);
        logic [1:0] tgt;
        tgt = addr[7:6];
        @(posedge clk); #1;
        s_rreq = 1'b1;
        s_addr = addr;
        s_bcnt = bcnt;
        for (int k = 0; k <= int'(bcnt); k++) begin
            exp_r.push_back({tgt, pcnt[tgt]});
            pcnt[tgt]++;
        end
        waited = 0;
        @(negedge clk);
        while (s_busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (s_busy) begin
            n_err++;
            $display("FAIL rd_timeout: addr %h got s_busy=1 for 200 cycles, required acceptance", addr);
        end else if (m_rreq !== (4'b0001 << tgt)) begin
            n_err++;
            $display("FAIL rd_route: got m_rreq=%b, required %b", m_rreq, 4'b0001 << tgt);
        end
        @(posedge clk); #1;
        s_rreq = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        s_rreq = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({s_rval, s_rdat, m_wreq, m_rreq} !== '0) begin
            n_err++;
            $display("FAIL reset_out: got rval=%b rdat=%h wreq=%b rreq=%b, required all 0",
                     s_rval, s_rdat, m_wreq, m_rreq);
        end
        @(posedge clk); #1;
        reset  = 1'b0;
        s_rreq = 1'b0;
    endtask

    task automatic test_write_burst();
        int w;
        wr_burst(8'h45, 4'd3, 8'hA0, 8'hC0, 4);
        wr_burst(8'hC0, 4'd0, 8'h77, 8'hC0, 1);
        rd(8'h00, 4'd0, w);
        n_vec++;
        if (w != 0) begin
            n_err++;
            $display("FAIL wr_idle_after: read got %0d stall cycles, required 0", w);
        end
        drain("wr");
        n_vec++;
        if (exp_w.size() != 0) begin
            n_err++;
            $display("FAIL wr_count: got %0d words undelivered, required 0", exp_w.size());
        end
    endtask

    task automatic test_read_order();
        int w1, w2, rc;
        lat = 4;
        rc  = rcount;
        rd(8'h80, 4'd1, w1);
        rd(8'h10, 4'd0, w2);
        n_vec++;
        if (w2 == 0 || rcount - rc != 2) begin
            n_err++;
            $display("FAIL rd_order: got stall=%0d words_before_accept=%0d, required stall>0 and 2",
                     w2, rcount - rc);
        end
        drain("order");
    endtask

    task automatic test_outstanding();
        int w[4];
        int rc;
        logic [DW-1:0] first;
        lat   = 8;
        first = {2'd3, pcnt[3]};
        rc    = rcount;
        fork
            begin
                for (int i = 0; i < 4; i++) rd(8'hC0, 4'd0, w[i]);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!m_rval[3] && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                n_vec++;
                if (s_rval !== 1'b0) begin
                    n_err++;
                    $display("FAIL rd_latency0: got s_rval=%b with m_rval[3], required 0", s_rval);
                end
                @(negedge clk);
                n_vec++;
                if (s_rval !== 1'b1 || s_rdat !== first) begin
                    n_err++;
                    $display("FAIL rd_latency1: got rval=%b rdat=%h, required 1 %h", s_rval, s_rdat, first);
                end
            end
        join
        n_vec++;
        if (w[0] != 0 || w[1] != 0 || w[2] != 0 || w[3] == 0) begin
            n_err++;
            $display("FAIL rd_pends: got stalls %0d %0d %0d %0d, required 0 0 0 >0", w[0], w[1], w[2], w[3]);
        end
        n_vec++;
        if (rcount - rc != 1) begin
            n_err++;
            $display("FAIL rd_pends_release: got %0d words before 4th accept, required 1", rcount - rc);
        end
        drain("pends");
    endtask

    task automatic test_busy_burst();
        busy_v[0] = 1'b1;
        fork
            wr_burst(8'h80, 4'd3, 8'h50, 8'h00, 4);
            begin
                repeat (3) @(posedge clk);
                #1 busy_v[2] = 1'b1;
                @(negedge clk);
                n_vec++;
                if (s_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_pass: got s_busy=%b, required 1", s_busy);
                end
                repeat (3) @(posedge clk);
                #1 busy_v[2] = 1'b0;
            end
        join
        busy_v = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_w.size() != 0) begin
            n_err++;
            $display("FAIL busy_words: got %0d words undelivered, required 0", exp_w.size());
        end
    endtask

    task automatic test_reset_mid();
        int w;
        lat = 10;
        rd(8'h80, 4'd3, w);
        wr_burst(8'h40, 4'd3, 8'h30, 8'h40, 2);
        @(posedge clk); #1;
        reset  = 1'b1;
        s_wreq = 1'b1;
        s_addr = 8'h40;
        s_wdat = 8'hEE;
        exp_r.delete();
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({s_rval, s_rdat, m_wreq, m_rreq} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_out: got rval=%b rdat=%h wreq=%b rreq=%b, required all 0",
                     s_rval, s_rdat, m_wreq, m_rreq);
        end
        @(posedge clk); #1;
        reset  = 1'b0;
        s_wreq = 1'b0;
        rd(8'h00, 4'd0, w);
        n_vec++;
        if (w != 0) begin
            n_err++;
            $display("FAIL rst_mid_read: got %0d stall cycles, required 0", w);
        end
        drain("rst");
        n_vec++;
        if (exp_w.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_words: got %0d words undelivered, required 0", exp_w.size());
        end
    endtask

    task automatic test_spurious();
        int w, rc;
        lat = 2;
        rc  = rcount;
        @(posedge clk); #1;
        spur = 4'b0011;
        repeat (2) @(posedge clk);
        #1 spur = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (rcount != rc) begin
            n_err++;
            $display("FAIL spur_rval: got %0d s_rval words, required 0", rcount - rc);
        end
        rd(8'h40, 4'd0, w);
        n_vec++;
        if (w != 0) begin
            n_err++;
            $display("FAIL spur_counts: read to slave 1 got %0d stall cycles, required 0", w);
        end
        drain("spur");
    endtask

    initial begin
        for (int j = 0; j < NS; j++) begin
            last_due[j] = 0;
            scnt[j]     = '0;
            pcnt[j]     = '0;
        end
        reset  = 1'b1;
        s_addr = '0;
        s_bcnt = '0;
        s_wreq = 1'b0;
        s_wdat = '0;
        s_rreq = 1'b0;
        test_reset();
        test_write_burst();
        test_read_order();
        test_outstanding();
        test_busy_burst();
        test_reset_mid();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmb_router.md
MMB_ROUTER -- requirements
Module: mmb_router

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 8, address width.
REQ-002 The block SHALL have parameter DWIDTH, default 8, data width.
REQ-003 The block SHALL have parameter BWIDTH, default 4, burst-count width.
REQ-004 The block SHALL have parameter SLAVES, default 4, number of downstream slaves; power of two, 2..16.
REQ-005 The block SHALL have parameter RDPENDS, default 3, maximum number of outstanding read transactions (at least 1).
REQ-006 SEL = log2(SLAVES); the slave index SHALL be s_addr[AWIDTH-1 -: SEL].
REQ-007 Ports SHALL be:
- reset  in  1  synchronous, active-high reset
- clk  in  1  the single clock
- s_addr  in  AWIDTH  upstream address
- s_bcnt  in  BWIDTH  upstream burst count
- s_wreq  in  1  upstream write request
- s_wdat  in  DWIDTH  upstream write data
- s_rreq  in  1  upstream read request
- s_rdat  out  DWIDTH  upstream read data
- s_rval  out  1  upstream read data valid
- s_busy  out  1  upstream stall
- m_addr  out  SLAVES x AWIDTH  per-slave address, full address unmodified
- m_bcnt  out  SLAVES x BWIDTH  per-slave burst count
- m_wreq  out  SLAVES  per-slave write request
- m_wdat  out  SLAVES x DWIDTH  per-slave write data
- m_rreq  out  SLAVES  per-slave read request
- m_rdat  in  SLAVES x DWIDTH  per-slave read data
- m_rval  in  SLAVES  per-slave read data valid
- m_busy  in  SLAVES  per-slave stall

Function
REQ-008 Burst length L SHALL equal s_bcnt+1 words; a word or read request is accepted when its request is high and s_busy is low.
REQ-009 m_addr, m_bcnt and m_wdat SHALL be driven to all slaves with s_addr, s_bcnt and s_wdat; only the target slave's m_wreq or m_rreq SHALL be asserted.
REQ-010 The write FSM SHALL have states IDLE and WBURST; IDLE latches the target index and L-1 remaining words on accepted first word with L>1, then moves to WBURST.
REQ-011 In WBURST, words SHALL route to the latched slave regardless of s_addr; the remaining count decrements per accepted word; at 0 the FSM returns to IDLE.
REQ-012 A write burst with L=1 SHALL complete in IDLE with no state change.
REQ-013 s_busy SHALL be combinational: m_busy of the target slave, OR the stall conditions of REQ-014..REQ-016.
REQ-014 s_rreq SHALL be stalled while the FSM is in WBURST.
REQ-015 A read SHALL be stalled when the registered outstanding transaction count equals RDPENDS.
REQ-016 A read to slave j SHALL be stalled while the registered pending-word count is nonzero and the current read slave rd_sel differs from j; this guarantees in-order return.
REQ-017 Each accepted read SHALL push L onto a RDPENDS-deep length FIFO, set rd_sel, and add L to the pending-word count.
REQ-018 Each m_rval[rd_sel] word SHALL decrement the pending-word count and the FIFO head remaining count; the head pops at 0.
REQ-019 A simultaneous push and pop SHALL leave the transaction count unchanged; a simultaneous read accept and word return SHALL net the word count (+L-1).
REQ-020 s_rdat and s_rval SHALL be registered from slave rd_sel, one-cycle latency; m_rval from any other slave SHALL be ignored.
REQ-021 Pending-word counter width SHALL be BWIDTH+log2(RDPENDS)+1, with no overflow at full load.
REQ-022 Simultaneous s_wreq and s_rreq is illegal upstream; behaviour is undefined.

Reset
REQ-023 Reset SHALL set the FSM to IDLE, clear the burst counter, FIFO, transaction count, pending-word count, rd_sel, s_rval=0 and s_rdat=0.
REQ-024 Reset mid-burst or mid-read SHALL abandon all state; read words arriving after reset SHALL be discarded (pending count 0).

Verification (SLAVES=4, AWIDTH=8)
REQ-025 Write, addr=0x45, bcnt=3, 4 words, second word with addr=0xC0 -> all 4 words on m_wreq[1]; FSM back in IDLE after the 4th word.
REQ-026 Read addr=0x80 bcnt=1, then read addr=0x10 next cycle -> the second read is stalled until both words from slave 2 are returned on s_rval, then accepted to slave 0.
REQ-027 Three reads to slave 3 with bcnt=0 and slave latency 8 -> the fourth read is stalled until the first word returns; s_rval follows m_rval[3] by 1 cycle.
REQ-028 m_busy[2]=1 during a WBURST to slave 2 -> s_busy=1 and no word is lost or duplicated; m_busy[0] has no effect on that burst.
REQ-029 Reset asserted after 2 of 4 write words, then read addr=0x00 -> FSM in IDLE, the read is accepted immediately, outputs are zero during reset.
REQ-030 Spurious m_rval[1] while rd_sel=0 -> s_rval stays 0 and the counts are unchanged.
